// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the fetch-stage next-PC sequencer.
package pc_ctrl_pkg;

  localparam int PC_W_DEF   = 16;
  localparam int PC_INC_DEF = 2;
  localparam int PERF_W     = 16;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    REDIR  = 2'd2,
    HALTED = 2'd3
  } state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count events, holding at the maximum value instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pc_control.sv
// Next-PC sequencer for the fetch stage: sequential advance, stalls,
// EX-stage redirects (deferred while a fetch is outstanding) and HALT.
// Optional build macro PC_CTRL_PERF_EN adds redirect/stall event counters.
module pc_control
  import pc_ctrl_pkg::*;
#(
  parameter int PC_W   = PC_W_DEF,
  parameter int PC_INC = PC_INC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [PC_W-1:0] pc_q,
  input  logic            imem_ready,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            halt,
  output logic [PC_W-1:0] next_pc,
  output logic            pc_we,
  output logic            fetch_req,
  output logic            flush,
  output logic            halted
`ifdef PC_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_redirects,
  output logic [PERF_W-1:0] perf_stalls
`endif
);

  state_t          state, state_d;
  logic [PC_W-1:0] pend_tgt, pend_tgt_d;

  // State and deferred redirect target registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pend_tgt <= '0;
    end else begin
      state    <= state_d;
      pend_tgt <= pend_tgt_d;
    end
  end

  // Next-state and Mealy outputs; redirect outranks halt, halt outranks stall.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state;
    pend_tgt_d = pend_tgt;
    next_pc    = pc_q;
    pc_we      = 1'b0;
    fetch_req  = 1'b0;
    flush      = 1'b0;
    unique case (state)
      BOOT: begin
        state_d = RUN;
      end
      RUN: begin
        fetch_req = 1'b1;
        if (redirect) begin
          flush = 1'b1;
          if (imem_ready) begin
            pc_we   = 1'b1;
            next_pc = redirect_target;
          end else begin
            // Fetch at pc_q still in flight: park the target until it lands.
            pend_tgt_d = redirect_target;
            state_d    = REDIR;
          end
        end else if (halt) begin
          state_d = HALTED;
        end else if (!stall && imem_ready) begin
          pc_we   = 1'b1;
          next_pc = pc_q + PC_W'(PC_INC);
        end
      end
      REDIR: begin
        fetch_req = 1'b1;
        if (redirect) begin
          pend_tgt_d = redirect_target;
          flush      = 1'b1;
        end
        if (imem_ready) begin
          pc_we   = 1'b1;
          flush   = 1'b1;
          next_pc = redirect ? redirect_target : pend_tgt;
          state_d = RUN;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  assign halted = (state == HALTED);

`ifdef PC_CTRL_PERF_EN
  logic stall_evt;
  assign stall_evt = (state == RUN) && stall && !redirect && !halt;

  sat_counter #(.W(PERF_W)) u_redirect_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush),
    .count (perf_redirects)
  );

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_evt),
    .count (perf_stalls)
  );
`else
  // Counters not built in this configuration.
`endif

endmodule
